// File: rtl/bus_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : bus_arbiter_if
// Description : Device-side bus bundle for bus_arbiter (FIFO heads in,
//               pop/push strobes and shared packet out, status).
// Revision    : 1.0 - initial release
// ============================================================================
interface bus_arbiter_if #(
  parameter int drvrs   = 4,
  parameter int pckg_sz = 16
);
  logic [drvrs-1:0]         pndng;
  logic [drvrs*pckg_sz-1:0] D_pop;
  logic [drvrs-1:0]         pop;
  logic [drvrs-1:0]         push;
  logic [pckg_sz-1:0]       D_push;
  logic [3:0]               grant_id;
  logic                     busy;
  logic                     drop;
  logic [7:0]               drop_cnt;

  modport master (
    input  pndng, D_pop,
    output pop, push, D_push, grant_id, busy, drop, drop_cnt
  );

  modport slave (
    output pndng, D_pop,
    input  pop, push, D_push, grant_id, busy, drop, drop_cnt
  );
endinterface
`default_nettype wire

// File: rtl/bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : bus_arbiter
// Description : Round-robin packet arbiter: pops one device FIFO, pushes the
//               packet to its destination(s); IDLE -> POP -> PUSH.
//               Optional macro ARB_DROP_CNT_EN enables the saturating drop_cnt.
// Revision    : 1.0 - initial release
// ============================================================================
module bus_arbiter #(
  parameter int         drvrs     = 4,
  parameter int         pckg_sz   = 16,
  parameter logic [7:0] broadcast = {8{1'b1}}
) (
  input wire            clk,
  input wire            reset,
  bus_arbiter_if.master bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_POP  = 2'd1,
    ST_PUSH = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [3:0]         r_grant_id;
  logic [3:0]         r_last_grant;
  logic [pckg_sz-1:0] r_d_push;

  logic [3:0]         w_rr_grant;
  logic [3:0]         w_hi_idx;
  logic [3:0]         w_lo_idx;
  logic               w_hi_found;
  logic [7:0]         w_dest;
  logic               w_dest_bcast;
  logic               w_dest_valid;
  logic [drvrs-1:0]   w_pop;
  logic [drvrs-1:0]   w_push;
  logic               w_drop;
  logic [pckg_sz-1:0] w_slot [16];

  // Fixed 16-entry view so a 4-bit grant index always selects in range
  generate
    for (genvar gi = 0; gi < 16; gi++) begin : g_slot
      if (gi < drvrs) begin : g_live
        assign w_slot[gi] = bus.D_pop[gi*pckg_sz +: pckg_sz];
      end else begin : g_tie
        assign w_slot[gi] = '0;
      end
    end
  endgenerate

  // Lowest pending index above last_grant wins, else lowest pending overall
  always_comb begin
    w_hi_found = 1'b0;
    w_hi_idx   = '0;
    w_lo_idx   = '0;
    for (int i = drvrs - 1; i >= 0; i--) begin
      if (bus.pndng[i]) begin
        if (4'(i) > r_last_grant) begin
          w_hi_found = 1'b1;
          w_hi_idx   = 4'(i);
        end else begin
          w_lo_idx = 4'(i);
        end
      end
    end
    w_rr_grant = w_hi_found ? w_hi_idx : w_lo_idx;
  end

  assign w_dest       = r_d_push[pckg_sz-1 -: 8];
  assign w_dest_bcast = (w_dest == broadcast);
  assign w_dest_valid = (w_dest < 8'(drvrs));

  always_comb begin
    w_state_nxt = r_state;
    w_pop       = '0;
    w_push      = '0;
    w_drop      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (|bus.pndng) w_state_nxt = ST_POP;
      end
      ST_POP: begin
        for (int i = 0; i < drvrs; i++) w_pop[i] = (r_grant_id == 4'(i));
        w_state_nxt = ST_PUSH;
      end
      ST_PUSH: begin
        if (w_dest_bcast) begin
          for (int i = 0; i < drvrs; i++) w_push[i] = (r_grant_id != 4'(i));
        end else if (w_dest_valid) begin
          for (int i = 0; i < drvrs; i++) w_push[i] = (w_dest == 8'(i));
        end else begin
          w_drop = 1'b1;
        end
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= ST_IDLE;
      r_grant_id   <= '0;
      r_last_grant <= 4'(drvrs - 1);
      r_d_push     <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == ST_IDLE && |bus.pndng) r_grant_id <= w_rr_grant;
      // Packet register doubles as D_push, so it holds outside PUSH
      if (r_state == ST_POP) r_d_push <= w_slot[r_grant_id];
      if (r_state == ST_PUSH) r_last_grant <= r_grant_id;
    end
  end

`ifdef ARB_DROP_CNT_EN
  logic [7:0] r_drop_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_drop_cnt <= '0;
    end else if (w_drop && r_drop_cnt != 8'hFF) begin
      r_drop_cnt <= r_drop_cnt + 8'd1;
    end
  end

  assign bus.drop_cnt = r_drop_cnt;
`else
  assign bus.drop_cnt = 8'd0;
`endif

  assign bus.pop      = w_pop;
  assign bus.push     = w_push;
  assign bus.D_push   = r_d_push;
  assign bus.grant_id = r_grant_id;
  assign bus.busy     = (r_state != ST_IDLE);
  assign bus.drop     = w_drop;

endmodule
`default_nettype wire

// File: tb/tb_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_bus_arbiter
// Description : Self-checking bench for bus_arbiter with a transaction-level
//               reference model; honours ARB_DROP_CNT_EN for drop_cnt.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bus_arbiter;
  localparam int N = 4;
  localparam int W = 16;

  logic clk = 1'b0;
  logic reset;
  int   errors = 0;
  int   checks = 0;
  int   m_last;
  int   m_drops;

  bus_arbiter_if #(.drvrs(N), .pckg_sz(W)) bus ();

  bus_arbiter #(.drvrs(N), .pckg_sz(W), .broadcast(8'hFF)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Round-robin: first pending device starting after the previous grant
  function automatic int exp_grant(input logic [N-1:0] p);
    for (int k = 1; k <= N; k++) begin
      int idx;
      idx = (m_last + k) % N;
      if (p[idx]) return idx;
    end
    return 0;
  endfunction

  function automatic logic [N-1:0] exp_push(input logic [W-1:0] pkt, input int g);
    logic [N-1:0] m;
    int           dest;
    dest = int'(pkt[W-1 -: 8]);
    m    = '0;
    if (dest == 255) begin
      m    = '1;
      m[g] = 1'b0;
    end else if (dest < N) begin
      m[dest] = 1'b1;
    end
    return m;
  endfunction

  task automatic txn(input logic [N-1:0] p, input logic [N*W-1:0] dp, input bit disturb);
    int           g;
    int           dest;
    logic [W-1:0] pkt;
    logic [N-1:0] oh;
    logic         exp_drop;
    bus.pndng = p;
    bus.D_pop = dp;
    g         = exp_grant(p);
    pkt       = dp[g*W +: W];
    dest      = int'(pkt[W-1 -: 8]);
    exp_drop  = (dest != 255) && (dest >= N);
    oh        = '0;
    oh[g]     = 1'b1;

    @(posedge clk); #1;
    chk("pop", bus.pop, oh);
    chk("grant_id", bus.grant_id, g);
    chk("busy_pop", bus.busy, 1);
    chk("push_in_pop", bus.push, 0);
    if (disturb) begin
      bus.pndng = N'($urandom);
      for (int i = 0; i < N; i++)
        if (i != g) bus.D_pop[i*W +: W] = W'($urandom);
    end

    @(posedge clk); #1;
    chk("push", bus.push, exp_push(pkt, g));
    chk("pop_in_push", bus.pop, 0);
    chk("D_push", bus.D_push, pkt);
    chk("drop", bus.drop, exp_drop);
    m_last = g;
`ifdef ARB_DROP_CNT_EN
    if (exp_drop && m_drops < 255) m_drops++;
`endif

    @(posedge clk); #1;
    chk("busy_idle", bus.busy, 0);
    chk("push_idle", bus.push, 0);
    chk("drop_idle", bus.drop, 0);
    chk("D_push_hold", bus.D_push, pkt);
    chk("drop_cnt", bus.drop_cnt, m_drops);
  endtask

  initial begin
    logic [N*W-1:0] dp;
    logic [N-1:0]   p;
    m_last    = N - 1;
    m_drops   = 0;
    reset     = 1'b0;
    bus.pndng = '0;
    bus.D_pop = '0;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_pop", bus.pop, 0);
    chk("rst_push", bus.push, 0);
    chk("rst_D_push", bus.D_push, 0);
    chk("rst_grant", bus.grant_id, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_drop", bus.drop, 0);
    chk("rst_drop_cnt", bus.drop_cnt, 0);
    reset = 1'b1;

    // Round-robin sweep with all devices pending, each packet to device 0
    dp = {16'h00A3, 16'h00A2, 16'h00A1, 16'h00A0};
    for (int k = 0; k < 5; k++) txn(4'b1111, dp, 1'b0);

    bus.pndng = '0;
    @(posedge clk); #1;
    chk("idle_no_req", bus.busy, 0);

    txn(4'b0100, {16'h0000, 16'h0155, 16'h0000, 16'h0000}, 1'b0);
    txn(4'b0010, {16'h0000, 16'h0000, 16'hFF3C, 16'h0000}, 1'b0);
    txn(4'b0001, {16'h0000, 16'h0000, 16'h0000, 16'h0700}, 1'b0);

    // Reset in the POP cycle aborts the transaction
    bus.pndng = 4'b0010;
    bus.D_pop = {16'h0000, 16'h0000, 16'h0011, 16'h0000};
    @(posedge clk); #1;
    chk("abort_pop_seen", bus.pop, 4'b0010);
    reset = 1'b0;
    #1;
    chk("abort_pop", bus.pop, 0);
    chk("abort_push", bus.push, 0);
    chk("abort_busy", bus.busy, 0);
    m_last  = N - 1;
    m_drops = 0;
    @(posedge clk); #1;
    chk("abort_push_rst", bus.push, 0);
    reset     = 1'b1;
    bus.pndng = '0;
    @(posedge clk); #1;
    chk("abort_push_rel", bus.push, 0);
    chk("abort_busy_rel", bus.busy, 0);
    txn(4'b1111, {16'h0003, 16'h0002, 16'h0001, 16'h0000}, 1'b0);

    // Random traffic with pndng/D_pop disturbed mid-transaction
    for (int k = 0; k < 40; k++) begin
      for (int i = 0; i < N; i++) begin
        int r;
        logic [7:0] d;
        r = int'($urandom_range(0, 5));
        if (r < 4)       d = 8'(r);
        else if (r == 4) d = 8'hFF;
        else             d = 8'($urandom_range(4, 254));
        dp[i*W +: W] = {d, 8'($urandom)};
      end
      p = N'($urandom_range(1, 15));
      txn(p, dp, 1'b1);
    end

    // Invalid destinations to drive the drop counter into saturation
    for (int k = 0; k < 300; k++) begin
      for (int i = 0; i < N; i++)
        dp[i*W +: W] = {8'($urandom_range(4, 254)), 8'($urandom)};
      p = '0;
      p[$urandom_range(0, N - 1)] = 1'b1;
      txn(p, dp, 1'b0);
    end
`ifdef ARB_DROP_CNT_EN
    chk("drop_cnt_sat", bus.drop_cnt, 255);
`else
    chk("drop_cnt_sat", bus.drop_cnt, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 SHALL have parameter drvrs, default 4, number of devices on the bus (2..16).
REQ-002 SHALL have parameter pckg_sz, default 16, packet width in bits (>= 9).
REQ-003 SHALL have parameter broadcast, default {8{1'b1}}, destination ID meaning "all devices".
REQ-004 SHALL have port clk, input, 1, single clock; all state updates on rising edge.
REQ-005 SHALL have port reset, input, 1, asynchronous active-low reset (reset==0 resets).
REQ-006 SHALL have port pndng, input, drvrs, per-device "FIFO non-empty" flag.
REQ-007 SHALL have port D_pop, input, drvrs*pckg_sz, per-device head-of-FIFO packet (device i at bits [i*pckg_sz +: pckg_sz]), first-word-fall-through.
REQ-008 SHALL have port pop, output, drvrs, one-hot pop strobe to the source device.
REQ-009 SHALL have port push, output, drvrs, push strobe mask to destination device(s).
REQ-010 SHALL have port D_push, output, pckg_sz, shared packet broadcast to all device inputs.
REQ-011 SHALL have port grant_id, output, 4, index of the device currently granted.
REQ-012 SHALL have port busy, output, 1, high while any state other than IDLE is active.
REQ-013 SHALL have port drop, output, 1, one-cycle pulse when a packet is discarded.
REQ-014 SHALL have port drop_cnt, output, 8, count of discarded packets.

Function
REQ-015 SHALL implement FSM states IDLE, POP, PUSH.
REQ-016 IDLE: if pndng!=0, select the first device with pndng set, searching round-robin starting at last_grant+1 modulo drvrs; register grant_id; go to POP. Otherwise stay in IDLE.
REQ-017 POP: assert pop[grant_id] for exactly one cycle; capture D_pop slice of grant_id into data register; go to PUSH.
REQ-018 PUSH: drive D_push = captured packet; assert push for exactly one cycle; set last_grant = grant_id; go to IDLE.
REQ-019 Destination field = packet bits [pckg_sz-1 -: 8].
REQ-020 dest == broadcast -> push = all ones except bit grant_id.
REQ-021 dest < drvrs -> push = one-hot at dest, including dest == source.
REQ-022 Any other dest -> push = 0, drop pulses in the PUSH cycle, packet discarded.
REQ-023 Fixed latency: pop one cycle after arbitration decision, push one cycle after pop; max throughput 1 packet per 3 cycles.
REQ-024 pndng changes during POP or PUSH SHALL NOT affect the in-flight transaction.
REQ-025 pop and push SHALL never be asserted in the same cycle; at most one pop bit high at a time.
REQ-026 D_push SHALL hold its last value outside PUSH.
REQ-027 drop_cnt SHALL saturate at 255.

Reset
REQ-028 reset==0 SHALL immediately force state=IDLE, pop=0, push=0, D_push=0, grant_id=0, busy=0, drop=0, drop_cnt=0, last_grant=drvrs-1 (so device 0 has first priority).
REQ-029 Reset asserted during POP or PUSH SHALL abort the transaction; no strobe completes after reset deassertion.
REQ-030 First arbitration SHALL occur on the first rising edge with reset==1.

Configuration
REQ-031 Macro ARB_DROP_CNT_EN: when defined, drop_cnt SHALL count drop pulses per REQ-027.
REQ-032 When ARB_DROP_CNT_EN is undefined, drop_cnt SHALL be tied to 0 with no counter logic; drop pulse still generated.

Verification
REQ-033 Bench SHALL cover: only pndng[2]=1, D_pop[2]=16'h0155 -> pop=4'b0100 for 1 cycle, next cycle push=4'b0010, D_push=16'h0155.
REQ-034 Bench SHALL cover: pndng=4'b1111 held, each device dest 0 -> grants in order 0,1,2,3,0; one pop every 3 cycles.
REQ-035 Bench SHALL cover: device 1 packet 16'hFF3C -> push=4'b1101, D_push=16'hFF3C.
REQ-036 Bench SHALL cover: device 0 packet 16'h0700 (dest 7 >= drvrs) -> push=0, drop=1 one cycle, drop_cnt=1 with ARB_DROP_CNT_EN, 0 without.
REQ-037 Bench SHALL cover: reset driven low in POP cycle -> pop, push, busy fall immediately; no push after release; next grant to device 0.
REQ-038 Bench SHALL cover: 300 invalid-destination packets with ARB_DROP_CNT_EN -> drop_cnt saturates at 255.
